// File: rtl/id_stage.sv
// id_stage -- RV32 instruction decode stage for a 16-entry register file.
//
// Purpose:
//   Splits the instruction word into register addresses, decodes the opcode
//   into a 16-bit control word and builds the sign-extended immediate. It also
//   forwards a same-cycle writeback value onto the operands. Everything except
//   the register-file read addresses is registered, giving one cycle of latency.
//
// Ports:
//   clk             in   1   clock, rising edge
//   rst             in   1   synchronous active-high reset
//   instruction     in  32   RV32 instruction word
//   pc              in  32   instruction address (reserved, unused)
//   rs1_addr        out  4   register-file read address 1 (combinational)
//   rs2_addr        out  4   register-file read address 2 (combinational)
//   rs1_data        in  32   register-file read data 1
//   rs2_data        in  32   register-file read data 2
//   wb_rd_addr      in   4   writeback destination register
//   wb_data         in  32   writeback value
//   wb_reg_write    in   1   writeback enable
//   control_signals out 16   decoded control word (registered)
//   immediate       out 32   sign-extended immediate (registered)
//   rd_addr         out  4   destination register (registered)
//   rs1_data_out    out 32   forwarded operand 1 (registered)
//   rs2_data_out    out 32   forwarded operand 2 (registered)
//
// Control word bit map:
//   [0] reg_write  [1] alu_src_imm  [2] mem_read  [3] mem_write
//   [4] mem_to_reg [5] jal          [6] jalr      [7] branch
//   [10:8] funct3  [11] instruction[30]  [13:12] alu_op
//   [14] lui       [15] auipc

module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    output logic [3:0]  rs1_addr,
    output logic [3:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [3:0]  wb_rd_addr,
    input  logic [31:0] wb_data,
    input  logic        wb_reg_write,
    output logic [15:0] control_signals,
    output logic [31:0] immediate,
    output logic [3:0]  rd_addr,
    output logic [31:0] rs1_data_out,
    output logic [31:0] rs2_data_out
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0]  w_opcode;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [15:0] w_ctrl;
    logic [31:0] w_imm;
    logic        w_known;
    logic        w_fwd1;
    logic        w_fwd2;
    logic        w_unused_pc;

    logic [15:0] r_ctrl_p1;
    logic [31:0] r_imm_p1;
    logic [3:0]  r_rd_p1;
    logic [31:0] r_op1_p1;
    logic [31:0] r_op2_p1;

    // pc is carried on the interface for later stages but not consumed here.
    assign w_unused_pc = ^pc;

    // Only the low four bits of each register field address the 16-entry file.
    assign rs1_addr = instruction[18:15];
    assign rs2_addr = instruction[23:20];
    assign w_opcode = instruction[6:0];

    assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u = {instruction[31:12], 12'b0};
    assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        w_ctrl  = '0;
        w_imm   = '0;
        w_known = 1'b1;
        unique case (w_opcode)
            OP_R: begin
                w_ctrl[0]     = 1'b1;
                w_ctrl[13:12] = 2'b10;
            end
            OP_I_ALU: begin
                w_ctrl[0]     = 1'b1;
                w_ctrl[1]     = 1'b1;
                w_ctrl[13:12] = 2'b11;
                w_imm         = w_imm_i;
            end
            OP_LOAD: begin
                w_ctrl[0] = 1'b1;
                w_ctrl[1] = 1'b1;
                w_ctrl[2] = 1'b1;
                w_ctrl[4] = 1'b1;
                w_imm     = w_imm_i;
            end
            OP_STORE: begin
                w_ctrl[1] = 1'b1;
                w_ctrl[3] = 1'b1;
                w_imm     = w_imm_s;
            end
            OP_BRANCH: begin
                // Branch is flagged unconditionally; the outcome is resolved downstream.
                w_ctrl[7]     = 1'b1;
                w_ctrl[13:12] = 2'b01;
                w_imm         = w_imm_b;
            end
            OP_JAL: begin
                w_ctrl[0] = 1'b1;
                w_ctrl[5] = 1'b1;
                w_imm     = w_imm_j;
            end
            OP_JALR: begin
                w_ctrl[0] = 1'b1;
                w_ctrl[1] = 1'b1;
                w_ctrl[6] = 1'b1;
                w_imm     = w_imm_i;
            end
            OP_LUI: begin
                w_ctrl[0]  = 1'b1;
                w_ctrl[14] = 1'b1;
                w_imm      = w_imm_u;
            end
            OP_AUIPC: begin
                w_ctrl[0]  = 1'b1;
                w_ctrl[15] = 1'b1;
                w_imm      = w_imm_u;
            end
            default: w_known = 1'b0;
        endcase
        // An unrecognised opcode yields an all-zero control word.
        if (w_known) begin
            w_ctrl[10:8] = instruction[14:12];
            w_ctrl[11]   = instruction[30];
        end
    end

    // Register 0 is hard-wired, so it is never a forwarding target.
    assign w_fwd1 = wb_reg_write && (wb_rd_addr == rs1_addr) && (rs1_addr != 4'd0);
    assign w_fwd2 = wb_reg_write && (wb_rd_addr == rs2_addr) && (rs2_addr != 4'd0);

    // ---- stage p0 -> p1 boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_p1 <= '0;
            r_imm_p1  <= '0;
            r_rd_p1   <= '0;
            r_op1_p1  <= '0;
            r_op2_p1  <= '0;
        end else begin
            r_ctrl_p1 <= w_ctrl;
            r_imm_p1  <= w_imm;
            r_rd_p1   <= instruction[10:7];
            r_op1_p1  <= w_fwd1 ? wb_data : rs1_data;
            r_op2_p1  <= w_fwd2 ? wb_data : rs2_data;
        end
    end

    assign control_signals = r_ctrl_p1;
    assign immediate       = r_imm_p1;
    assign rd_addr         = r_rd_p1;
    assign rs1_data_out    = r_op1_p1;
    assign rs2_data_out    = r_op2_p1;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic [15:0] control_signals;
    logic [31:0] immediate;
    logic [3:0]  rd_addr;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;

    int n_vec;
    int n_err;

    id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .instruction     (instruction),
        .pc              (pc),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .wb_rd_addr      (wb_rd_addr),
        .wb_data         (wb_data),
        .wb_reg_write    (wb_reg_write),
        .control_signals (control_signals),
        .immediate       (immediate),
        .rd_addr         (rd_addr),
        .rs1_data_out    (rs1_data_out),
        .rs2_data_out    (rs2_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] ins;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  wba;
        logic [31:0] wbd;
        logic        wbwe;
        logic [15:0] e_ctrl;
        logic [31:0] e_imm;
        logic [3:0]  e_rd;
        logic [31:0] e_o1;
        logic [31:0] e_o2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] ins, d1, d2, input logic [3:0] wba,
                                input logic [31:0] wbd, input logic wbwe,
                                input logic [15:0] e_ctrl, input logic [31:0] e_imm,
                                input logic [3:0] e_rd, input logic [31:0] e_o1, e_o2);
        vec_t v;
        v.ins = ins; v.d1 = d1; v.d2 = d2; v.wba = wba; v.wbd = wbd; v.wbwe = wbwe;
        v.e_ctrl = e_ctrl; v.e_imm = e_imm; v.e_rd = e_rd; v.e_o1 = e_o1; v.e_o2 = e_o2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: control word as a sum of named flags per opcode,
    // immediate as integer arithmetic on the instruction fields.
    localparam int RW = 1, AIMM = 2, MR = 4, MW = 8, M2R = 16, JAL = 32, JALR = 64, BR = 128;
    localparam int LUI = 16384, AUIPC = 32768, AOP = 4096;

    function automatic void ref_model(input logic [31:0] ins, d1, d2, input logic [3:0] wba,
                                      input logic [31:0] wbd, input logic wbwe,
                                      output logic [15:0] ctrl, output logic [31:0] imm,
                                      output logic [3:0] rd, output logic [31:0] o1, o2);
        int c;
        int s;
        int a1;
        int a2;
        int neg;
        bit known;
        known = 1;
        c = 0;
        s = 0;
        neg = ins[31] ? 1 : 0;
        case (ins[6:0])
            7'h33: c = RW + 2 * AOP;
            7'h13: begin c = RW + AIMM + 3 * AOP; s = int'(ins[31:20]) - neg * 4096; end
            7'h03: begin c = RW + AIMM + MR + M2R; s = int'(ins[31:20]) - neg * 4096; end
            7'h23: begin
                c = AIMM + MW;
                s = int'(ins[31:25]) * 32 + int'(ins[11:7]) - neg * 4096;
            end
            7'h63: begin
                c = BR + AOP;
                s = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - neg * 4096;
            end
            7'h6F: begin
                c = JAL + RW;
                s = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                    - neg * 1048576;
            end
            7'h67: begin c = JALR + RW + AIMM; s = int'(ins[31:20]) - neg * 4096; end
            7'h37: begin c = LUI + RW; s = int'(ins[31:12]) * 4096; end
            7'h17: begin c = AUIPC + RW; s = int'(ins[31:12]) * 4096; end
            default: known = 0;
        endcase
        if (known) c = c + int'(ins[14:12]) * 256 + int'(ins[30]) * 2048;
        ctrl = c[15:0];
        imm  = s;
        rd   = ins[10:7];
        a1   = int'(ins[18:15]);
        a2   = int'(ins[23:20]);
        o1   = (wbwe && a1 != 0 && int'(wba) == a1) ? wbd : d1;
        o2   = (wbwe && a2 != 0 && int'(wba) == a2) ? wbd : d2;
    endfunction

    task automatic drive(input vec_t v);
        instruction  = v.ins;
        rs1_data     = v.d1;
        rs2_data     = v.d2;
        wb_rd_addr   = v.wba;
        wb_data      = v.wbd;
        wb_reg_write = v.wbwe;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input vec_t v);
        chk({tag, ".ctrl"}, {16'h0, control_signals}, {16'h0, v.e_ctrl});
        chk({tag, ".imm"},  immediate, v.e_imm);
        chk({tag, ".rd"},   {28'h0, rd_addr}, {28'h0, v.e_rd});
        chk({tag, ".op1"},  rs1_data_out, v.e_o1);
        chk({tag, ".op2"},  rs2_data_out, v.e_o2);
    endtask

    initial begin
        vec_t v;
        logic [31:0] r;
        logic [6:0]  ops [10];
        n_vec = 0;
        n_err = 0;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

        // ADDI x3,x2,0x10, no writeback
        vecs.push_back(mk(32'h01010193, 32'h11111111, 32'h22222222, 4'd0, 32'h0, 1'b0,
                          16'h3003, 32'h10, 4'd3, 32'h11111111, 32'h22222222));
        // ADDI x2,x2,0 with writeback to x2 -> forwarded
        vecs.push_back(mk(32'h00010113, 32'h0, 32'h33, 4'd2, 32'hCAFEBABE, 1'b1,
                          16'h3003, 32'h0, 4'd2, 32'hCAFEBABE, 32'h33));
        // same, writeback disabled
        vecs.push_back(mk(32'h00010113, 32'h0, 32'h33, 4'd2, 32'hCAFEBABE, 1'b0,
                          16'h3003, 32'h0, 4'd2, 32'h0, 32'h33));
        // BEQ +8 and BEQ -4
        vecs.push_back(mk(32'h00000463, 32'h7, 32'h8, 4'd0, 32'h0, 1'b0,
                          16'h1080, 32'h8, 4'd8, 32'h7, 32'h8));
        vecs.push_back(mk(32'hFE000EE3, 32'h7, 32'h8, 4'd0, 32'h0, 1'b0,
                          16'h1880, 32'hFFFFFFFC, 4'hD, 32'h7, 32'h8));
        // ADDI x1,x0,5: writeback to x0 must not forward
        vecs.push_back(mk(32'h00500093, 32'h5, 32'h44, 4'd0, 32'hDEAD0000, 1'b1,
                          16'h3003, 32'h5, 4'd1, 32'h5, 32'h44));
        // ADD x5,x6,x7 with writeback to x7 -> forwarded on operand 2
        vecs.push_back(mk(32'h007302B3, 32'h66, 32'h77, 4'd7, 32'h12345678, 1'b1,
                          16'h2001, 32'h0, 4'd5, 32'h66, 32'h12345678));
        // unrecognised opcode
        vecs.push_back(mk(32'hFFFFFFFF, 32'h1, 32'h2, 4'd3, 32'h9, 1'b1,
                          16'h0000, 32'h0, 4'hF, 32'h1, 32'h2));
        // branch with each funct3 and arbitrary operands (rs1=x1, rs2=x2)
        begin
            int f3 [6] = '{0, 1, 4, 5, 6, 7};
            logic [31:0] a [6] = '{32'd10, 32'hFFFFFFFB, 32'd9, 32'd11, 32'd0, 32'hFFFFFFFF};
            logic [31:0] b [6] = '{32'd11, 32'd2, 32'd3, 32'd10, 32'd0, 32'd1};
            for (int i = 0; i < 6; i++) begin
                logic [2:0] f;
                f = f3[i][2:0];
                vecs.push_back(mk({12'h002, 5'd1, f, 5'd0, 7'h63}, a[i], b[i], 4'd0, 32'h0, 1'b0,
                                  {5'b00010, f, 8'h80}, 32'h0, 4'd0, a[i], b[i]));
            end
        end

        // reset state
        pc = 32'h0;
        rst = 1'b1;
        drive(vecs[0]);
        #1;
        chk("rst.rs1_addr_comb", {28'h0, rs1_addr}, 32'd2);
        step;
        check_regs("rst", mk(32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0,
                             16'h0, 32'h0, 4'd0, 32'h0, 32'h0));
        rst = 1'b0;

        // directed table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            pc = $urandom();
            #1;
            chk($sformatf("tbl%0d.rs1_addr", i), {28'h0, rs1_addr}, {28'h0, vecs[i].ins[18:15]});
            chk($sformatf("tbl%0d.rs2_addr", i), {28'h0, rs2_addr}, {28'h0, vecs[i].ins[23:20]});
            step;
            check_regs($sformatf("tbl%0d", i), vecs[i]);
        end

        // reset pulse mid-stream, then resume
        drive(vecs[0]);
        step;
        check_regs("pre_rst", vecs[0]);
        rst = 1'b1;
        step;
        check_regs("mid_rst", mk(32'h0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0,
                                 16'h0, 32'h0, 4'd0, 32'h0, 32'h0));
        chk("mid_rst.rs1_addr_comb", {28'h0, rs1_addr}, 32'd2);
        rst = 1'b0;
        step;
        check_regs("post_rst", vecs[0]);

        // randomized against reference model
        for (int i = 0; i < 400; i++) begin
            int k;
            r = $urandom();
            v.ins = {r[31:7], ops[$urandom_range(0, 9)]};
            v.d1 = $urandom();
            v.d2 = $urandom();
            v.wbd = $urandom();
            v.wbwe = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 3);
            if (k == 0)      v.wba = v.ins[18:15];
            else if (k == 1) v.wba = v.ins[23:20];
            else             v.wba = 4'($urandom_range(0, 15));
            ref_model(v.ins, v.d1, v.d2, v.wba, v.wbd, v.wbwe,
                      v.e_ctrl, v.e_imm, v.e_rd, v.e_o1, v.e_o2);
            drive(v);
            pc = $urandom();
            step;
            check_regs($sformatf("rnd%0d[%08h]", i, v.ins), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
